// File: rtl/cross_bar_arbiter.sv
// Per-slave arbiter that pairs masters with slaves by address decode and
// drives the master/slave select fields consumed by cross_bar_mux.
module cross_bar_arbiter #(
    parameter int unsigned MASTER_N    = 4,
    parameter int unsigned SLAVE_N     = 4,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ARB_MODE    = 0,
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic [MASTER_N-1:0]           master_req,
    input  logic [MASTER_N*ADDR_W-1:0]    master_addr,
    input  logic [SLAVE_N-1:0]            slave_ack,
    output logic [MASTER_N*$clog2(SLAVE_N+1)-1:0] master_mux,
    output logic [SLAVE_N*$clog2(MASTER_N+1)-1:0] slave_mux,
    output logic [SLAVE_N-1:0]            timeout_err
);

    localparam int unsigned MW  = $clog2(MASTER_N + 1);
    localparam int unsigned SW  = $clog2(SLAVE_N + 1);
    localparam int unsigned DW  = $clog2(SLAVE_N);
    localparam int unsigned MIW = (MASTER_N > 1) ? $clog2(MASTER_N) : 1;
    localparam int unsigned CW  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_GRANT   = 2'd1,
        S_RELEASE = 2'd2
    } state_e;

    state_e           state_q [SLAVE_N];
    logic [MIW-1:0]   owner_q [SLAVE_N];
    logic [MIW-1:0]   ptr_q   [SLAVE_N];
    logic [CW-1:0]    cnt_q   [SLAVE_N];

    logic [MASTER_N*SW-1:0] master_mux_q;
    logic [SLAVE_N*MW-1:0]  slave_mux_q;
    logic [SLAVE_N-1:0]     timeout_err_q;

    logic [MASTER_N-1:0] busy_c;
    logic [MASTER_N-1:0] cand_c  [SLAVE_N];
    logic [MIW-1:0]      win_c   [SLAVE_N];
    logic [SLAVE_N-1:0]  win_vld_c;
    logic                unused_addr_c;

    // Only the address MSBs take part in the decode.
    assign unused_addr_c = ^master_addr;

    // A master is busy while any slave holds it in GRANT or RELEASE.
    always_comb begin
        busy_c = '0;
        for (int s = 0; s < int'(SLAVE_N); s++) begin
            if (state_q[s] != S_IDLE) begin
                busy_c[owner_q[s]] = 1'b1;
            end
        end
    end

    // Candidate set and winner per slave (round-robin from ptr or lowest index).
    always_comb begin
        logic [MIW:0] idx;
        idx       = '0;
        win_vld_c = '0;
        for (int s = 0; s < int'(SLAVE_N); s++) begin
            win_c[s]  = '0;
            cand_c[s] = '0;
            for (int m = 0; m < int'(MASTER_N); m++) begin
                cand_c[s][m] = master_req[m] && !busy_c[m] &&
                    (master_addr[m*ADDR_W + ADDR_W - 1 -: DW] == DW'(s));
            end
            for (int k = 0; k < int'(MASTER_N); k++) begin
                if (ARB_MODE == 0) begin
                    idx = {1'b0, ptr_q[s]} + (MIW+1)'(k);
                    if (idx >= (MIW+1)'(MASTER_N)) begin
                        idx = idx - (MIW+1)'(MASTER_N);
                    end
                end else begin
                    idx = (MIW+1)'(k);
                end
                if (!win_vld_c[s] && cand_c[s][idx[MIW-1:0]]) begin
                    win_vld_c[s] = 1'b1;
                    win_c[s]     = idx[MIW-1:0];
                end
            end
        end
    end

    // Per-slave FSM with registered select and timeout outputs.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            master_mux_q  <= '0;
            slave_mux_q   <= '0;
            timeout_err_q <= '0;
            for (int s = 0; s < int'(SLAVE_N); s++) begin
                state_q[s] <= S_IDLE;
                owner_q[s] <= '0;
                ptr_q[s]   <= '0;
                cnt_q[s]   <= '0;
            end
        end else begin
            timeout_err_q <= '0;
            for (int s = 0; s < int'(SLAVE_N); s++) begin
                case (state_q[s])
                    S_IDLE: begin
                        if (win_vld_c[s]) begin
                            state_q[s] <= S_GRANT;
                            owner_q[s] <= win_c[s];
                            cnt_q[s]   <= '0;
                            slave_mux_q[s*MW +: MW]        <= MW'(win_c[s]) + MW'(1);
                            master_mux_q[win_c[s]*SW +: SW] <= SW'(s + 1);
                            if (ARB_MODE == 0) begin
                                ptr_q[s] <= (win_c[s] == MIW'(MASTER_N - 1)) ?
                                            '0 : win_c[s] + MIW'(1);
                            end
                        end
                    end
                    S_GRANT: begin
                        if (slave_ack[s]) begin
                            state_q[s] <= S_RELEASE;
                            slave_mux_q[s*MW +: MW]          <= '0;
                            master_mux_q[owner_q[s]*SW +: SW] <= '0;
                        end else if ((TIMEOUT_CYC > 0) &&
                                     (cnt_q[s] == CW'(TIMEOUT_CYC - 1))) begin
                            state_q[s]       <= S_RELEASE;
                            timeout_err_q[s] <= 1'b1;
                            slave_mux_q[s*MW +: MW]          <= '0;
                            master_mux_q[owner_q[s]*SW +: SW] <= '0;
                        end else begin
                            cnt_q[s] <= cnt_q[s] + CW'(1);
                        end
                    end
                    S_RELEASE: begin
                        // Wait for the finished master to drop req before re-arming.
                        if (!master_req[owner_q[s]]) begin
                            state_q[s] <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q[s] <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign master_mux  = master_mux_q;
    assign slave_mux   = slave_mux_q;
    assign timeout_err = timeout_err_q;

endmodule
